// File: rtl/pipe_control.sv
// Hazard control for an in-order pipeline: per-stage tracking, load-use stall,
// branch flush, operand forwarding select and retirement count. Define
// PIPE_CONTROL_FWD_EN to enable forwarding; otherwise RAW hazards stall until clear.
module pipe_control #(
    parameter int STAGES  = 5,
    parameter int ADDRW   = 5,
    parameter int BRSTAGE = STAGES - 1,
    parameter int LDSTAGE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [ADDRW-1:0]           id_ra,
    input  logic [ADDRW-1:0]           id_rb,
    input  logic                       id_usea,
    input  logic                       id_useb,
    input  logic [ADDRW-1:0]           id_rd,
    input  logic                       id_regwrite,
    input  logic                       id_memread,
    input  logic                       branch_taken,
    output logic                       stall,
    output logic                       flush,
    output logic [STAGES-1:0]          valid,
    output logic [$clog2(STAGES)-1:0]  fwd_a,
    output logic [$clog2(STAGES)-1:0]  fwd_b,
    output logic [31:0]                retired
);

    localparam int FW = $clog2(STAGES);
    localparam logic [ADDRW-1:0] XZR = '1;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic             usea;
        logic             useb;
        logic [ADDRW-1:0] rd;
        logic [ADDRW-1:0] ra;
        logic [ADDRW-1:0] rb;
    } entry_t;

    if (STAGES < 4 || STAGES > 8 || BRSTAGE < 2 || BRSTAGE > STAGES - 1 ||
        LDSTAGE < 3 || LDSTAGE > STAGES - 1) begin : g_bad_params
        $error("pipe_control: parameter outside legal range");
    end

    entry_t pipe_q [STAGES-1:2];
    entry_t pipe_d [STAGES-1:2];
    entry_t id_entry;
    logic   hazard;

    // True when the ID instruction reads register rd (XZR never creates a dependency).
    function automatic logic id_reads(input logic [ADDRW-1:0] rd,
                                      input logic [ADDRW-1:0] ra,
                                      input logic [ADDRW-1:0] rb,
                                      input logic usea,
                                      input logic useb);
        return (rd != XZR) && ((usea && ra == rd) || (useb && rb == rd));
    endfunction

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
        id_entry.usea     = id_usea;
        id_entry.useb     = id_useb;
        id_entry.rd       = id_rd;
        id_entry.ra       = id_ra;
        id_entry.rb       = id_rb;
    end

    // NOTE: combinational blocks use blocking assignments with a default first,
    // so every path assigns every output and no latch is inferred.
    always_comb begin
        hazard = 1'b0;
`ifdef PIPE_CONTROL_FWD_EN
        for (int k = 2; k < LDSTAGE; k++) begin
            if (pipe_q[k].valid && pipe_q[k].memread &&
                id_reads(pipe_q[k].rd, id_ra, id_rb, id_usea, id_useb))
                hazard = 1'b1;
        end
`else
        for (int k = 2; k < STAGES; k++) begin
            if (pipe_q[k].valid && pipe_q[k].regwrite &&
                id_reads(pipe_q[k].rd, id_ra, id_rb, id_usea, id_useb))
                hazard = 1'b1;
        end
`endif
        hazard = hazard && id_valid;
    end

    assign flush = branch_taken && pipe_q[BRSTAGE].valid;
    assign stall = hazard && !flush;

    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
`ifdef PIPE_CONTROL_FWD_EN
        // Scan oldest to youngest so the youngest producer is the final winner.
        for (int k = STAGES - 1; k >= 3; k--) begin
            if (pipe_q[k].valid && pipe_q[k].regwrite && pipe_q[k].rd != XZR &&
                (!pipe_q[k].memread || k >= LDSTAGE)) begin
                if (pipe_q[2].usea && pipe_q[k].rd == pipe_q[2].ra) fwd_a = FW'(k);
                if (pipe_q[2].useb && pipe_q[k].rd == pipe_q[2].rb) fwd_b = FW'(k);
            end
        end
`endif
    end

    always_comb begin
        for (int k = 3; k < STAGES; k++) pipe_d[k] = pipe_q[k-1];
        pipe_d[2] = stall ? entry_t'('0) : id_entry;
        if (flush) begin
            for (int k = 2; k <= BRSTAGE; k++) pipe_d[k] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the stage array is
    // small control state and is reset so no stale entry survives a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 2; k < STAGES; k++) pipe_q[k] <= '0;
            retired <= '0;
        end else begin
            for (int k = 2; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
            if (pipe_q[STAGES-1].valid) retired <= retired + 32'd1;
        end
    end

    // Fetch always holds an instruction; IF/ID validity comes from the ID register.
    always_comb begin
        valid    = '0;
        valid[0] = 1'b1;
        valid[1] = id_valid;
        for (int k = 2; k < STAGES; k++) valid[k] = pipe_q[k].valid;
    end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control (STAGES=5): table of per-cycle vectors plus
// hand-written flush and mid-stream reset sequences.
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_ra, id_rb, id_rd;
    logic       id_usea, id_useb, id_regwrite, id_memread;
    logic       branch_taken;
    logic       stall, flush;
    logic [4:0] valid;
    logic [2:0] fwd_a, fwd_b;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

`ifdef PIPE_CONTROL_FWD_EN
    localparam int BASE = 13;
`else
    localparam int BASE = 8;
`endif

    typedef struct {
        int iv, ra, rb, ua, ub, rd, rw, mr, bt;
        int st, fl, vld, fa, fb, ret;
    } vec_t;

    vec_t vecs[$];

    pipe_control dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_usea(id_usea), .id_useb(id_useb), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .stall(stall), .flush(flush),
        .valid(valid), .fwd_a(fwd_a), .fwd_b(fwd_b), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int iv, int ra, int rb, int ua, int ub, int rd, int rw,
                                int mr, int bt, int st, int fl, int vld, int fa, int fb,
                                int ret);
        vec_t v;
        v.iv = iv; v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub; v.rd = rd; v.rw = rw;
        v.mr = mr; v.bt = bt; v.st = st; v.fl = fl; v.vld = vld; v.fa = fa; v.fb = fb;
        v.ret = ret;
        return v;
    endfunction

    function automatic vec_t idle(int vld, int fa, int fb, int ret);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, vld, fa, fb, ret);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_id(int iv, int ra, int rb, int ua, int ub, int rd, int rw, int mr, int bt);
        id_valid     = 1'(iv);
        id_ra        = 5'(ra);
        id_rb        = 5'(rb);
        id_usea      = 1'(ua);
        id_useb      = 1'(ub);
        id_rd        = 5'(rd);
        id_regwrite  = 1'(rw);
        id_memread   = 1'(mr);
        branch_taken = 1'(bt);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        set_id(v.iv, v.ra, v.rb, v.ua, v.ub, v.rd, v.rw, v.mr, v.bt);
        #1;
        check($sformatf("v%0d stall", idx),   32'(stall),   32'(v.st));
        check($sformatf("v%0d flush", idx),   32'(flush),   32'(v.fl));
        check($sformatf("v%0d valid", idx),   32'(valid),   32'(v.vld));
        check($sformatf("v%0d fwd_a", idx),   32'(fwd_a),   32'(v.fa));
        check($sformatf("v%0d fwd_b", idx),   32'(fwd_b),   32'(v.fb));
        check($sformatf("v%0d retired", idx), retired,      32'(v.ret));
    endtask

    initial begin
        // independent instructions fill and drain the pipe
        vecs.push_back(mk(1, 10, 11, 1, 1, 1, 1, 0, 0, 0, 0, 'b00011, 0, 0, 0));
        vecs.push_back(mk(1, 12, 13, 1, 1, 2, 1, 0, 0, 0, 0, 'b00111, 0, 0, 0));
        vecs.push_back(mk(1, 14, 15, 1, 1, 4, 1, 0, 0, 0, 0, 'b01111, 0, 0, 0));
        vecs.push_back(idle('b11101, 0, 0, 0));
        vecs.push_back(idle('b11001, 0, 0, 1));
        vecs.push_back(idle('b10001, 0, 0, 2));
        vecs.push_back(idle('b00001, 0, 0, 3));
        // XZR writer and unused-source gating never create a hazard
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 'b00011, 0, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0, 'b00111, 0, 0, 3));
        vecs.push_back(mk(1, 31, 5, 1, 0, 6, 1, 0, 0, 0, 0, 'b01111, 0, 0, 3));
        vecs.push_back(idle('b11101, 0, 0, 3));
        vecs.push_back(idle('b11001, 0, 0, 4));
        vecs.push_back(idle('b10001, 0, 0, 5));
        vecs.push_back(idle('b00001, 0, 0, 6));
`ifdef PIPE_CONTROL_FWD_EN
        // ALU result forwarded from stage 3
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'b00011, 0, 0, 6));
        vecs.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 'b00111, 0, 0, 6));
        vecs.push_back(idle('b01101, 3, 0, 6));
        vecs.push_back(idle('b11001, 0, 0, 6));
        vecs.push_back(idle('b10001, 0, 0, 7));
        // load-use: one stall cycle, bubble in EX, then forward from stage 4
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 'b00011, 0, 0, 8));
        vecs.push_back(mk(1, 2, 2, 1, 1, 9, 1, 0, 0, 1, 0, 'b00111, 0, 0, 8));
        vecs.push_back(mk(1, 2, 2, 1, 1, 9, 1, 0, 0, 0, 0, 'b01011, 0, 0, 8));
        vecs.push_back(idle('b10101, 4, 4, 8));
        vecs.push_back(idle('b01001, 0, 0, 9));
        vecs.push_back(idle('b10001, 0, 0, 9));
        vecs.push_back(idle('b00001, 0, 0, 10));
        // two writers of X4: the younger one in stage 3 wins
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 'b00011, 0, 0, 10));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 'b00111, 0, 0, 10));
        vecs.push_back(mk(1, 4, 0, 1, 0, 8, 1, 0, 0, 0, 0, 'b01111, 0, 0, 10));
        vecs.push_back(idle('b11101, 3, 0, 10));
        vecs.push_back(idle('b11001, 0, 0, 11));
        vecs.push_back(idle('b10001, 0, 0, 12));
        vecs.push_back(idle('b00001, 0, 0, 13));
`else
        // RAW on X3 stalls until the producer leaves WB; no forwarding
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 'b00011, 0, 0, 6));
        vecs.push_back(mk(1, 3, 7, 1, 1, 5, 1, 0, 0, 1, 0, 'b00111, 0, 0, 6));
        vecs.push_back(mk(1, 3, 7, 1, 1, 5, 1, 0, 0, 1, 0, 'b01011, 0, 0, 6));
        vecs.push_back(mk(1, 3, 7, 1, 1, 5, 1, 0, 0, 1, 0, 'b10011, 0, 0, 6));
        vecs.push_back(mk(1, 3, 7, 1, 1, 5, 1, 0, 0, 0, 0, 'b00011, 0, 0, 7));
        vecs.push_back(idle('b00101, 0, 0, 7));
        vecs.push_back(idle('b01001, 0, 0, 7));
        vecs.push_back(idle('b10001, 0, 0, 7));
        vecs.push_back(idle('b00001, 0, 0, 8));
`endif

        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("reset valid", 32'(valid), 32'b00001);
        check("reset retired", retired, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset flush", 32'(flush), 32'd0);
        check("reset fwd", 32'({fwd_a, fwd_b}), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // branch in WB with a load-use pending in ID: flush wins
        @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("br s0 valid", 32'(valid), 32'b00011);
        @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("br s1 valid", 32'(valid), 32'b00111);
        @(negedge clk); set_id(1, 0, 0, 0, 0, 2, 1, 1, 1);
        #1 check("br s2 flush without wb valid", 32'(flush), 32'd0);
        check("br s2 valid", 32'(valid), 32'b01111);
        @(negedge clk); set_id(1, 2, 0, 1, 0, 9, 1, 0, 0);
        #1 check("br s3 stall pending", 32'(stall), 32'd1);
        branch_taken = 1'b1;
        #1 check("br s3 flush", 32'(flush), 32'd1);
        check("br s3 stall overridden", 32'(stall), 32'd0);
        check("br s3 valid", 32'(valid), 32'b11111);
        check("br s3 retired", retired, 32'(BASE));
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("br s4 valid", 32'(valid), 32'b00001);
        check("br s4 flush", 32'(flush), 32'd0);
        check("br s4 retired", retired, 32'(BASE + 1));

        // stream of instructions, then reset mid-stream
        repeat (6) begin
            @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        #1 check("stream retired", retired, 32'(BASE + 4));
        check("stream valid", 32'(valid), 32'b11111);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("rst mid valid", 32'(valid), 32'b00001);
        check("rst mid retired", retired, 32'd0);
        @(negedge clk);
        #1 check("rst held retired", retired, 32'd0);
        check("rst held valid", 32'(valid), 32'b00001);
        rst = 1'b1;
        @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("resume valid", 32'(valid), 32'b00101);
        @(negedge clk);
        @(negedge clk);
        #1 check("resume wb valid", 32'(valid), 32'b10001);
        check("resume retired before", retired, 32'd0);
        @(negedge clk);
        #1 check("resume retired", retired, 32'd1);
        check("resume drained", 32'(valid), 32'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter STAGES, 5, pipeline depth (0=IF, 1=ID, 2=EX, STAGES-1=WB); legal range 4..8.
REQ-002 SHALL have parameter ADDRW, 5, register address width; address all-ones is XZR.
REQ-003 SHALL have parameter BRSTAGE, STAGES-1, stage whose valid branch_taken redirects fetch; legal range 2..STAGES-1.
REQ-004 SHALL have parameter LDSTAGE, 3, first stage at which load data is forwardable; legal range 3..STAGES-1.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port id_valid  input  1  IF/ID holds a real instruction.
REQ-008 SHALL have ports id_ra, id_rb  input  ADDRW each  source registers of the ID instruction.
REQ-009 SHALL have ports id_usea, id_useb  input  1 each  the ID instruction reads id_ra / id_rb.
REQ-010 SHALL have port id_rd  input  ADDRW  destination of the ID instruction.
REQ-011 SHALL have ports id_regwrite, id_memread  input  1 each  ID instruction writes a register / is a load.
REQ-012 SHALL have port branch_taken  input  1  branch resolved taken in stage BRSTAGE.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID, inject bubble into EX.
REQ-014 SHALL have port flush  output  1  squash all stages younger than BRSTAGE.
REQ-015 SHALL have port valid  output  STAGES  per-stage valid bits, bit k = stage k.
REQ-016 SHALL have ports fwd_a, fwd_b  output  $clog2(STAGES) each  EX operand source: 0 = register file, k = result held in stage k.
REQ-017 SHALL have port retired  output  32  count of valid instructions leaving WB.

Function
REQ-018 SHALL keep one entry per stage k>=2: valid, rd, regwrite, memread, ra, rb, usea, useb.
REQ-019 Each cycle without stall or flush, entry k SHALL load entry k-1 for k>=3, and EX SHALL load the ID inputs with valid=id_valid.
REQ-020 valid[0] SHALL be 1 after reset; valid[1] SHALL equal id_valid.
REQ-021 Load-use: stall SHALL be 1 combinationally when id_valid and any valid memread entry in stages 2..LDSTAGE-1 has rd equal to a used ID source, with rd != XZR.
REQ-022 On stall, EX SHALL receive a bubble (valid=0, regwrite=0, memread=0) and stages >=3 SHALL advance normally.
REQ-023 flush SHALL equal branch_taken AND valid[BRSTAGE].
REQ-024 On flush, entries 2..BRSTAGE SHALL become invalid at the next edge, and older stages SHALL advance normally.
REQ-025 flush SHALL override stall: stall output SHALL be 0 while flush is 1.
REQ-026 fwd_a SHALL be the smallest k in 3..STAGES-1 whose valid regwrite entry has rd==EX.ra, rd!=XZR and EX.usea, else 0; fwd_b SHALL be the same for rb. The youngest producer wins.
REQ-027 An entry with memread SHALL be eligible for forwarding only at k>=LDSTAGE.
REQ-028 retired SHALL increment by 1 on each edge where valid[STAGES-1] is 1, wrapping 2^32-1 to 0.
REQ-029 All outputs except stall, flush, fwd_a and fwd_b SHALL be registered; those four SHALL be combinational from entries and inputs.

Reset
REQ-030 While rst=0, all entries SHALL be invalid with fields 0, and retired=0.
REQ-031 After reset, valid=1 only in bit 0, and stall, flush, fwd_a and fwd_b SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight entries immediately, with no retirement counted.

Configuration
REQ-033 Macro PIPE_CONTROL_FWD_EN defined: forwarding SHALL operate per REQ-026/027 and stall per REQ-021.
REQ-034 Macro absent: fwd_a and fwd_b SHALL be tied to 0, and stall SHALL assert on any RAW match (used source == rd, valid, regwrite, rd!=XZR) against stages 2..STAGES-1.

Verification
REQ-035 STAGES=5: ADD X1 at EX, next ID instruction reads X1 -> next cycle fwd_a=3, stall=0.
REQ-036 LDUR X2 at EX, ID reads X2 -> stall=1 for exactly 1 cycle; valid[2]=0 the following cycle; fwd_a=4 when the consumer reaches EX.
REQ-037 Writer to X31 at EX, ID reads X31 -> stall=0; fwd_a=0.
REQ-038 branch_taken=1 with valid[4]=1 while a load-use stall is pending -> flush=1, stall=0; valid[3:2]=0 next cycle.
REQ-039 Without PIPE_CONTROL_FWD_EN: ADD X3 at EX, ID reads X3 -> stall held 3 cycles; fwd_a/fwd_b stay 0.
REQ-040 Retire 10 instructions, pulse rst low mid-stream -> retired=0 and valid=5'b00001 immediately; counting resumes from 0.
